// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with 16x oversampling and an FWFT receive FIFO.
//
// The serial line is synchronised through two flops and oversampled by a tick
// generator running at 16 ticks per bit. Each bit is decided by a 3-sample
// majority vote taken at ticks t7, t8 and t9. Received bytes go into a
// first-word-fall-through FIFO that is read over a valid/ready stream.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. A parity
// bit then follows the data bits. A byte whose parity is wrong is discarded
// and reported on frame_err_o at the stop-bit decision.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous reset, active-high
//   srst_i      synchronous clear, same effect as rst_i
//   uart_rx_i   serial line, idle high, asynchronous to clk_i
//   out_val_o   FIFO not empty
//   out_data_o  FIFO head byte (0 while the FIFO is empty)
//   out_rdy_i   consumer ready; a pop happens on out_val_o & out_rdy_i
//   count_o     current FIFO occupancy
//   frame_err_o one-cycle pulse on a bad stop bit (or on a parity error)
//   overrun_o   sticky: a byte was dropped because the FIFO was full
module uart_rx #(
   parameter int CLK_HZ     = 12_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          srst_i,
   input  logic                          uart_rx_i,
   output logic                          out_val_o,
   output logic [7:0]                    out_data_o,
   input  logic                          out_rdy_i,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          frame_err_o,
   output logic                          overrun_o
);

   localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
   localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   if (DIV < 2) begin : g_bad_div
      $error("uart_rx: clock divider DIV must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif

   // ---------------------------------------------------------------
   // Input synchroniser and start-edge detection
   // ---------------------------------------------------------------
   logic       sync1;
   logic       line;
   logic       line_prev;
   logic [1:0] settle;

   // line_prev only tracks the line once the synchroniser has refilled after a
   // reset. Until then it reads 0, so a line that is still low when reset is
   // released has to be seen high before it can produce a start edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1     <= 1'b1;
         line      <= 1'b1;
         settle    <= 2'b00;
         line_prev <= 1'b0;
      end else if (srst_i) begin
         sync1     <= 1'b1;
         line      <= 1'b1;
         settle    <= 2'b00;
         line_prev <= 1'b0;
      end else begin
         sync1     <= uart_rx_i;
         line      <= sync1;
         settle    <= {settle[0], 1'b1};
         line_prev <= settle[1] ? line : 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Tick generator, bit sampling and receive FSM
   // ---------------------------------------------------------------
   logic [2:0]    state;
   logic [DW-1:0] div_cnt;
   logic [3:0]    phase;
   logic [2:0]    bit_idx;
   logic [3:0]    high_cnt;
   logic          samp7;
   logic          samp8;
   logic [7:0]    shift;
   logic          tick;
   logic          at_t7;
   logic          at_t8;
   logic          at_t9;
   logic          at_t15;
   logic          maj;
   logic          start_edge;
   logic          stop_decide;
   logic          push_req;
   logic          frame_err_set;

   assign tick       = (div_cnt == DIV_LAST);
   assign at_t7      = tick && (phase == 4'd7);
   assign at_t8      = tick && (phase == 4'd8);
   assign at_t9      = tick && (phase == 4'd9);
   assign at_t15     = tick && (phase == 4'd15);
   // The third sample is the live line value at t9.
   assign maj        = (samp7 & samp8) | (samp7 & line) | (samp8 & line);
   assign start_edge = (state == S_IDLE) && line_prev && !line;
   assign stop_decide = (state == S_STOP) && at_t9;

`ifdef UART_RX_PARITY_EN
   logic par_ok;
   assign push_req      = stop_decide && maj && par_ok;
   assign frame_err_set = stop_decide && !(maj && par_ok);
`else
   assign push_req      = stop_decide && maj;
   assign frame_err_set = stop_decide && !maj;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         div_cnt     <= '0;
         phase       <= '0;
         bit_idx     <= '0;
         high_cnt    <= '0;
         frame_err_o <= 1'b0;
      end else if (srst_i) begin
         state       <= S_IDLE;
         div_cnt     <= '0;
         phase       <= '0;
         bit_idx     <= '0;
         high_cnt    <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= frame_err_set;
         if (start_edge) begin
            // Realign bit timing to the falling edge of the start bit.
            div_cnt <= '0;
            phase   <= '0;
            state   <= S_START;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
               phase <= phase + 1'b1;
            end
            case (state)
               S_IDLE: begin
               end
               S_START: begin
                  if (at_t9 && maj) begin
                     state <= S_IDLE;
                  end else if (at_t15) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end
               end
               S_DATA: begin
                  if (at_t15) begin
                     if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (at_t15) begin
                     state <= S_STOP;
                  end
               end
`endif
               S_STOP: begin
                  // Decide at t9 so the next start edge is never missed.
                  if (at_t9) begin
                     state    <= maj ? S_IDLE : S_BREAK;
                     high_cnt <= '0;
                  end
               end
               S_BREAK: begin
                  if (!line) begin
                     high_cnt <= '0;
                  end else if (tick) begin
                     if (high_cnt == 4'd15) begin
                        state <= S_IDLE;
                     end else begin
                        high_cnt <= high_cnt + 1'b1;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Sample and shift registers carry data only and need no reset: each is
   // written before the FSM ever consumes it.
   always_ff @(posedge clk_i) begin
      if (at_t7) begin
         samp7 <= line;
      end
      if (at_t8) begin
         samp8 <= line;
      end
      if ((state == S_DATA) && at_t9) begin
         shift <= {maj, shift[7:1]};
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: the parity bit equals the XOR of the data bits.
      if ((state == S_PARITY) && at_t9) begin
         par_ok <= (maj == (^shift));
      end
`endif
   end

   // ---------------------------------------------------------------
   // First-word-fall-through receive FIFO
   // ---------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          pop;
   logic          push;

   assign full = (count == FULL_COUNT);
   assign pop  = out_val_o && out_rdy_i;
   // A same-cycle pop frees a slot, so a push into a full FIFO still succeeds.
   assign push = push_req && (!full || pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_o <= 1'b0;
      end else if (srst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_o <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (push_req && full && !pop) begin
            overrun_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= shift;
      end
   end

   assign out_val_o  = (count != '0);
   assign out_data_o = out_val_o ? mem[rd_ptr] : 8'h00;
   assign count_o    = count;

endmodule
